// File: rtl/alu_issue_queue.sv
// In-order issue queue between a command producer and an ALU.
// Buffers up to DEPTH commands, rejects opcode 15, and registers the issue port.
module alu_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 4,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [DATA_WIDTH-1:0] i_cmd_a,
    input  logic [DATA_WIDTH-1:0] i_cmd_b,
    input  logic [INST_WIDTH-1:0] i_cmd_inst,
    input  logic                  i_issue_en,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_data_a,
    output logic [DATA_WIDTH-1:0] o_data_b,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic                  o_valid,
    output logic [CW-1:0]         o_count,
    output logic                  o_illegal,
    output logic [7:0]            o_illegal_cnt
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    localparam logic [CW-1:0]         FULL    = CW'(DEPTH);
    localparam logic [INST_WIDTH-1:0] ILLEGAL = INST_WIDTH'(15);

    entry_t        mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          handshake;
    logic          illegal;
    logic          store;
    logic          pop;
    entry_t        head_entry;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign o_cmd_ready = (o_count != FULL);
    assign handshake   = i_cmd_valid & o_cmd_ready;
    assign illegal     = handshake & (i_cmd_inst == ILLEGAL);
    assign store       = handshake & ~illegal & ~i_flush;
    // Pre-edge count gates the pop, so a same-edge push can never bypass.
    assign pop         = i_issue_en & (o_count != '0) & ~i_flush;
    assign head_entry  = mem[head];

    // Storage is not reset; head/tail/count define which slots are live.
    always_ff @(posedge i_clk) begin
        if (store) begin
            mem[tail] <= '{a: i_cmd_a, b: i_cmd_b, inst: i_cmd_inst};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head    <= '0;
            tail    <= '0;
            o_count <= '0;
        end else if (i_flush) begin
            head    <= '0;
            tail    <= '0;
            o_count <= '0;
        end else begin
            if (store) tail <= tail + AW'(1);
            if (pop)   head <= head + AW'(1);
            case ({store, pop})
                2'b10:   o_count <= o_count + CW'(1);
                2'b01:   o_count <= o_count - CW'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_a <= '0;
            o_data_b <= '0;
            o_inst   <= '0;
            o_valid  <= 1'b0;
        end else if (pop) begin
            o_data_a <= head_entry.a;
            o_data_b <= head_entry.b;
            o_inst   <= head_entry.inst;
            o_valid  <= 1'b1;
        end else begin
            o_data_a <= '0;
            o_data_b <= '0;
            o_inst   <= '0;
            o_valid  <= 1'b0;
        end
    end

    // Rejection bookkeeping is independent of flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_illegal     <= 1'b0;
            o_illegal_cnt <= '0;
        end else begin
            o_illegal <= illegal;
            if (illegal && o_illegal_cnt != 8'hFF) o_illegal_cnt <= o_illegal_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed plus random bench for alu_issue_queue against a queue-based reference model.
module tb_alu_issue_queue;

    localparam int DW = 32;
    localparam int IW = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic [IW-1:0] cmd_inst = '0;
    logic          issue_en = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic [IW-1:0] inst;
    logic          valid;
    logic [2:0]    count;
    logic          illegal;
    logic [7:0]    illegal_cnt;

    alu_issue_queue #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_inst(cmd_inst),
        .i_issue_en(issue_en), .i_flush(flush),
        .o_data_a(data_a), .o_data_b(data_b), .o_inst(inst), .o_valid(valid),
        .o_count(count), .o_illegal(illegal), .o_illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [IW-1:0] i;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] m_a, m_b;
    logic [IW-1:0] m_i;
    logic          m_valid, m_ill;
    int            m_cnt;
    int            errors = 0;
    int            checks = 0;
    int            issued = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_a = '0; m_b = '0; m_i = '0;
        m_valid = 1'b0; m_ill = 1'b0; m_cnt = 0;
    endtask

    task automatic check_all();
        chk("valid", 32'(valid), 32'(m_valid));
        chk("data_a", data_a, m_a);
        chk("data_b", data_b, m_b);
        chk("inst", 32'(inst), 32'(m_i));
        chk("count", 32'(count), q.size());
        chk("ready", 32'(cmd_ready), 32'(q.size() != DEPTH));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("illegal_cnt", 32'(illegal_cnt), m_cnt);
    endtask

    // One clock: drive inputs, advance model from pre-edge state, check after the edge.
    task automatic step(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [IW-1:0] in, input logic ie, input logic fl);
        bit hs, ill, pp;
        ent_t e;
        cmd_valid = v; cmd_a = a; cmd_b = b; cmd_inst = in; issue_en = ie; flush = fl;
        hs  = v && (q.size() != DEPTH);
        ill = hs && (in == 4'd15);
        pp  = ie && (q.size() != 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_valid = 1'b0; m_a = '0; m_b = '0; m_i = '0;
        end else begin
            if (pp) begin
                e = q.pop_front();
                m_valid = 1'b1; m_a = e.a; m_b = e.b; m_i = e.i;
                issued++;
            end else begin
                m_valid = 1'b0; m_a = '0; m_b = '0; m_i = '0;
            end
            if (hs && !ill) q.push_back('{a: a, b: b, i: in});
        end
        m_ill = ill;
        if (ill && m_cnt < 255) m_cnt++;
        #1;
        check_all();
    endtask

    initial begin
        int n;
        model_reset();
        #3;
        check_all();
        chk("reset_ready_low_count", 32'(count), 0);
        #4 rst_n = 1'b1;

        // Single command: issued after the second edge only.
        step(1, 5, 3, 0, 1, 0);
        chk("single_not_yet", 32'(valid), 0);
        step(0, 0, 0, 0, 1, 0);
        chk("single_valid", 32'(valid), 1);
        chk("single_a", data_a, 5);
        chk("single_b", data_b, 3);
        step(0, 0, 0, 0, 1, 0);
        chk("single_after", 32'(valid), 0);

        // Fill and backpressure.
        for (int i = 1; i <= 5; i++) step(1, 32'(i * 10), 32'(i), IW'(i), 0, 0);
        chk("fill_count", 32'(count), 4);
        chk("fill_ready", 32'(cmd_ready), 0);
        step(1, 50, 5, 5, 1, 0);
        step(1, 50, 5, 5, 1, 0);
        chk("fill_push5", 32'(inst), 2);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
        chk("fill_drained", 32'(count), 0);

        // Wrap-around with back-to-back traffic.
        n = issued;
        for (int i = 0; i < 10; i++) begin
            step(1, 32'(100 + i), 32'(i), IW'(i), 1, 0);
            chk("wrap_count_le1", 32'(count <= 1), 1);
        end
        step(0, 0, 0, 0, 1, 0);
        chk("wrap_issued", issued - n, 10);

        // Illegal opcode and saturation.
        step(1, 1, 1, 15, 1, 0);
        chk("ill_pulse", 32'(illegal), 1);
        chk("ill_cnt1", 32'(illegal_cnt), 1);
        step(0, 0, 0, 0, 1, 0);
        chk("ill_not_issued", 32'(valid), 0);
        chk("ill_pulse_end", 32'(illegal), 0);
        for (int i = 0; i < 300; i++) step(1, 0, 0, 15, 0, 0);
        chk("ill_sat", 32'(illegal_cnt), 255);

        // Flush with concurrent push and pop.
        for (int i = 0; i < 3; i++) step(1, 32'(i), 0, IW'(i + 1), 0, 0);
        step(1, 77, 77, 7, 1, 1);
        chk("flush_count", 32'(count), 0);
        chk("flush_valid", 32'(valid), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        chk("flush_idle", 32'(valid), 0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) step(1, 32'(i + 9), 1, IW'(i + 1), 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("areset_pre_valid", 32'(valid), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        chk("areset_no_issue", 32'(valid), 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [IW-1:0] ri;
            ri = ($urandom_range(0, 9) == 0) ? IW'(15) : IW'($urandom_range(0, 14));
            step(1'($urandom_range(0, 1)), $urandom, $urandom, ri,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
